tinyvga_pmod_capture: RTL and testbench

Receive-side decoder for the TinyVGA PMOD byte and 1-bit audio PWM that our demo tops drive. It recovers sync timing and pixel coordinates and unscrambles the 2-bit RGB, and it demodulates the first-order PWM back to a 10-bit sample. It sits in the verification and loopback harness: it feeds frame dumps, checksums and audio capture, and it can sit behind a bridge on another tile.

---
 rtl/vga_capture_pkg.sv | 36 +++
 rtl/pwm_window_demod.sv | 36 +++
 rtl/tinyvga_pmod_capture.sv | 130 +++++++++++++
 tb/tb_tinyvga_pmod_capture.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_capture_pkg.sv
// Shared constants and helpers for the TinyVGA PMOD receive path.
// Bit positions follow the PMOD byte {hsync, B0, G0, R0, vsync, B1, G1, R1}.
package vga_capture_pkg;

  localparam int HS = 7;
  localparam int B0 = 6;
  localparam int G0 = 5;
  localparam int R0 = 4;
  localparam int VS = 3;
  localparam int B1 = 2;
  localparam int G1 = 1;
  localparam int R1 = 0;

  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_V_TOTAL  = 525;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_H_OFFSET = 144;
  localparam int DEF_V_OFFSET = 35;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb_t;

  // The high colour bit sits in the low nibble, so each channel is reassembled.
  function automatic rgb_t unscramble(input logic [7:0] p);
    rgb_t c;
    c.r = {p[R1], p[R0]};
    c.g = {p[G1], p[G0]};
    c.b = {p[B1], p[B0]};
    return c;
  endfunction

endpackage

// File: rtl/pwm_window_demod.sv
// Counts ones of a PWM bitstream over fixed 1024-clock windows and
// emits the saturated 10-bit density once per window.
module pwm_window_demod (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwm_bit,
  output logic [9:0] sample,
  output logic       strobe
);

  logic [9:0]  wcnt;
  logic [10:0] ones;
  logic [10:0] total;

  // The bit arriving on the window's last clock still belongs to that window.
  assign total = ones + {10'd0, pwm_bit};

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt   <= '0;
      ones   <= '0;
      sample <= '0;
      strobe <= 1'b0;
    end else begin
      wcnt   <= wcnt + 10'd1;
      strobe <= (wcnt == 10'h3FF);
      if (wcnt == 10'h3FF) begin
        sample <= total[10] ? 10'h3FF : total[9:0];
        ones   <= '0;
      end else begin
        ones <= total;
      end
    end
  end

endmodule

// File: rtl/tinyvga_pmod_capture.sv
// Receive-side TinyVGA PMOD decoder: recovers sync timing, pixel coordinates
// and 2-bit RGB, and demodulates the 1-bit audio PWM to 10-bit samples.
module tinyvga_pmod_capture
  import vga_capture_pkg::*;
#(
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int H_OFFSET = DEF_H_OFFSET,
  parameter int V_OFFSET = DEF_V_OFFSET
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pmod_in,
  input  logic       audio_in,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [1:0] pix_r,
  output logic [1:0] pix_g,
  output logic [1:0] pix_b,
  output logic       pix_sof,
  output logic       pix_eol,
  output logic       locked,
  output logic [9:0] audio_sample,
  output logic       audio_valid
);

  localparam logic [10:0] H_LO  = 11'(H_OFFSET);
  localparam logic [10:0] H_HI  = 11'(H_OFFSET + H_ACTIVE);
  localparam logic [9:0]  V_LO  = 10'(V_OFFSET);
  localparam logic [9:0]  V_HI  = 10'(V_OFFSET + V_ACTIVE);
  localparam logic [11:0] H_LEN = 12'(H_TOTAL);
  localparam logic [9:0]  V_LEN = 10'(V_TOTAL);
  localparam logic [9:0]  X_END = 10'(H_ACTIVE - 1);

  logic [7:0]  pmod1;
  logic        audio1;
  logic        hs1, vs1, hs2, vs2;
  logic        hs_edge, vs_edge;
  logic [10:0] hcount;
  logic [9:0]  vline;
  logic        line_ok, frame_ok;
  logic        active;
  logic [9:0]  x_now, y_now;
  rgb_t        col;

  assign hs1     = pmod1[HS];
  assign vs1     = pmod1[VS];
  assign hs_edge = hs2 & ~hs1;
  assign vs_edge = vs2 & ~vs1;

  assign active = (hcount >= H_LO) && (hcount < H_HI) &&
                  (vline  >= V_LO) && (vline  < V_HI);
  assign x_now  = 10'(hcount - H_LO);
  assign y_now  = vline - V_LO;
  assign col    = unscramble(pmod1);

  // NOTE: every register here uses <=, so edge detection and the counters all
  // see the previous clock's values; blocking writes would skew them by a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Syncs clear low so an idle-high input after reset cannot fake an edge.
      pmod1     <= '0;
      audio1    <= 1'b0;
      hs2       <= 1'b0;
      vs2       <= 1'b0;
      hcount    <= '1;
      vline     <= '1;
      line_ok   <= 1'b0;
      frame_ok  <= 1'b0;
      locked    <= 1'b0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_r     <= '0;
      pix_g     <= '0;
      pix_b     <= '0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
    end else begin
      pmod1  <= pmod_in;
      audio1 <= audio_in;
      hs2    <= hs1;
      vs2    <= vs1;

      if (hs_edge) begin
        line_ok <= ({1'b0, hcount} + 12'd1 == H_LEN);
        hcount  <= '0;
      end else if (hcount != 11'h7FF) begin
        hcount <= hcount + 11'd1;
      end

      // A coincident hsync edge is swallowed by the vsync reset of vline.
      if (vs_edge) begin
        frame_ok <= (vline == V_LEN);
        vline    <= '0;
      end else if (hs_edge && vline != 10'h3FF) begin
        vline <= vline + 10'd1;
      end

      locked <= line_ok & frame_ok;

      pix_valid <= active;
      pix_sof   <= active && (x_now == '0) && (y_now == '0);
      pix_eol   <= active && (x_now == X_END);
      if (active) begin
        pix_x <= x_now;
        pix_y <= y_now;
        pix_r <= col.r;
        pix_g <= col.g;
        pix_b <= col.b;
      end else begin
        pix_r <= '0;
        pix_g <= '0;
        pix_b <= '0;
      end
    end
  end

  pwm_window_demod u_audio (
    .clk     (clk),
    .reset   (reset),
    .pwm_bit (audio1),
    .sample  (audio_sample),
    .strobe  (audio_valid)
  );

endmodule

// File: tb/tb_tinyvga_pmod_capture.sv
// Directed bench for tinyvga_pmod_capture using a reduced 40x30 raster
// (16x12 active) and sigma-delta audio windows.
module tb_tinyvga_pmod_capture;

  localparam int HT  = 40;
  localparam int VT  = 30;
  localparam int HA  = 16;
  localparam int VA  = 12;
  localparam int HO  = 10;
  localparam int VO  = 5;
  localparam int HSW = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pmod_in = 8'hFF;
  logic       audio_in = 1'b0;
  logic       pix_valid, pix_sof, pix_eol, locked, audio_valid;
  logic [9:0] pix_x, pix_y, audio_sample;
  logic [1:0] pix_r, pix_g, pix_b;

  tinyvga_pmod_capture #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA),
    .V_ACTIVE(VA), .H_OFFSET(HO), .V_OFFSET(VO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pmod_in      (pmod_in),
    .audio_in     (audio_in),
    .pix_valid    (pix_valid),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_r        (pix_r),
    .pix_g        (pix_g),
    .pix_b        (pix_b),
    .pix_sof      (pix_sof),
    .pix_eol      (pix_eol),
    .locked       (locked),
    .audio_sample (audio_sample),
    .audio_valid  (audio_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pixel stream monitor: expected coordinates advance in raster order.
  int valid_cnt = 0, sof_cnt = 0, eol_cnt = 0;
  int coord_err = 0, color_err = 0, flag_err = 0;
  int mon_x = 0, mon_y = 0;
  int ex_r = 0, ex_g = 0, ex_b = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (pix_valid) begin
        valid_cnt++;
        if (int'(pix_x) != mon_x || int'(pix_y) != mon_y) coord_err++;
        if (int'(pix_r) != ex_r || int'(pix_g) != ex_g || int'(pix_b) != ex_b) color_err++;
        if (pix_sof != (mon_x == 0 && mon_y == 0)) flag_err++;
        if (pix_eol != (mon_x == HA - 1)) flag_err++;
        if (pix_sof) sof_cnt++;
        if (pix_eol) eol_cnt++;
        mon_x++;
        if (mon_x == HA) begin
          mon_x = 0;
          mon_y++;
          if (mon_y == VA) mon_y = 0;
        end
      end else begin
        if (pix_r != 2'd0 || pix_g != 2'd0 || pix_b != 2'd0) color_err++;
        if (pix_sof || pix_eol) flag_err++;
      end
    end
  end

  task automatic drive_frame(input int stretch, input bit coinc, input logic [7:0] col,
                             input int er, input int eg, input int eb,
                             input int lock_exp, input string tag);
    int v0, s0, e0, len;
    logic hs, vs;
    ex_r = er; ex_g = eg; ex_b = eb;
    v0 = valid_cnt; s0 = sof_cnt; e0 = eol_cnt;
    for (int v = 0; v < VT; v++) begin
      len = (v == stretch) ? HT + 1 : HT;
      for (int h = 0; h < len; h++) begin
        @(negedge clk);
        if (coinc && v == 0 && h == 2) begin
          check({tag, "_hcount0"}, int'(dut.hcount), 0);
          check({tag, "_vline0"}, int'(dut.vline), 0);
        end
        if (lock_exp >= 0 && v == 10 && h == 5)
          check({tag, "_locked"}, int'(locked), lock_exp);
        if (stretch >= 0 && v == stretch + 1 && h == 5)
          check({tag, "_lock_drop"}, int'(locked), 0);
        hs = (h >= HSW);
        if (coinc) vs = !(v == 0 || v == 1);
        else       vs = !((v == 0 && h >= HT / 2) || v == 1 || (v == 2 && h < HT / 2));
        pmod_in = (col & 8'h77) | {hs, 3'b000, vs, 3'b000};
      end
    end
    check({tag, "_pixels"}, valid_cnt - v0, HA * VA);
    check({tag, "_sof"}, sof_cnt - s0, 1);
    check({tag, "_eol"}, eol_cnt - e0, VA);
  endtask

  // Audio: t indexes negedges from reset release; hist keeps every driven bit.
  int t = 0;
  bit hist [16384];
  logic [9:0] acc = '0;

  task automatic drive_audio(input int mode);
    logic [10:0] sum;
    case (mode)
      0: audio_in = 1'b0;
      1: audio_in = 1'b1;
      default: begin
        sum = {1'b0, acc} + 11'd300;
        audio_in = sum[10];
        acc = sum[9:0];
      end
    endcase
    hist[t] = audio_in;
  endtask

  // want >= 0: fixed expectation; want == -2: density from the bit history.
  task automatic audio_window(input int mode, input int want, input string tag);
    int n = 0;
    int s = 0;
    while (1) begin
      @(negedge clk);
      t++;
      n++;
      if (audio_valid || n >= 2000) break;
      drive_audio(mode);
    end
    drive_audio(mode);
    check({tag, "_gap"}, n, 1024);
    if (want >= 0) begin
      check(tag, int'(audio_sample), want);
    end else if (want == -2 && t >= 1025) begin
      for (int i = t - 1025; i <= t - 2; i++) s += int'(hist[i]);
      check(tag, int'(audio_sample), (s > 1023) ? 1023 : s);
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pmod_in  = 8'($urandom);
      audio_in = 1'($urandom);
    end
    @(negedge clk);
    check("rst_valid", int'(pix_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_xy", int'({pix_x, pix_y}), 0);
    check("rst_rgb", int'({pix_r, pix_g, pix_b}), 0);
    check("rst_flags", int'({pix_sof, pix_eol}), 0);
    check("rst_audio", int'(audio_sample), 0);
    check("rst_astrobe", int'(audio_valid), 0);
    reset    = 1'b0;
    pmod_in  = 8'hFF;
    audio_in = 1'b0;
    hist[0]  = 1'b0;

    fork
      begin
        repeat (4) @(negedge clk);
        drive_frame(-1, 1'b0, 8'hA9, 2, 1, 0, 0, "f1");
        drive_frame(-1, 1'b0, 8'h56, 1, 2, 3, 1, "f2");
        drive_frame(10, 1'b0, 8'h77, 3, 3, 3, 1, "f3_stretch");
        drive_frame(-1, 1'b0, 8'h14, 1, 0, 2, 1, "f4");
        drive_frame(-1, 1'b1, 8'hA9, 2, 1, 0, -1, "f5_coinc");
        drive_frame(-1, 1'b0, 8'h56, 1, 2, 3, 1, "f6");
      end
      begin
        audio_window(0, 0, "aud_first");
        audio_window(1, -2, "aud_to_ones");
        audio_window(1, 1023, "aud_ones");
        audio_window(2, -2, "aud_to_300");
        audio_window(2, -2, "aud_300_a");
        audio_window(2, -2, "aud_300_b");
        audio_window(0, -2, "aud_to_zero");
        audio_window(0, 0, "aud_zero");
      end
    join

    check("coord_errors", coord_err, 0);
    check("colour_errors", color_err, 0);
    check("flag_errors", flag_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
